jtag_shift_master: RTL and testbench

// - JTAG initiator: drives TCK/TMS/TDI and captures TDO for the e203 debug TAP on the FPGA board.
// - Replaces an external probe for on-board bring-up and self-test.
// - Accepts one command per transaction: either a TMS walk or a shift of up to MAX_BITS bits.
// - Returns the captured TDO bits on a valid/ready response channel.

---
 rtl/jtag_master_pkg.sv | 13 +
 rtl/jtag_shift_master_if.sv | 27 ++
 rtl/jtag_tck_timer.sv | 40 ++++
 rtl/jtag_shift_master.sv | 165 ++++++++++++++++
 tb/tb_jtag_shift_master.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_master_pkg.sv
// Shared state encoding and parameter defaults for the JTAG shift master.
package jtag_master_pkg;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_MAX_BITS = 64;
  localparam int unsigned DEF_LEN_W    = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/jtag_shift_master_if.sv
// Command/response channel between a requester and the JTAG shift master.
interface jtag_shift_master_if #(
  parameter int unsigned MAX_BITS = jtag_master_pkg::DEF_MAX_BITS,
  parameter int unsigned LEN_W    = jtag_master_pkg::DEF_LEN_W
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_tms_md;
  logic                cmd_exit;
  logic [LEN_W-1:0]    cmd_len;
  logic [MAX_BITS-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [MAX_BITS-1:0] rsp_tdo;

  modport master (
    output cmd_valid, cmd_tms_md, cmd_exit, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo
  );

  modport slave (
    input  cmd_valid, cmd_tms_md, cmd_exit, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo
  );

endinterface

// File: rtl/jtag_tck_timer.sv
// TCK half-period down-counter: load restarts it, expire_o flags the final cycle.
module jtag_tck_timer #(
  parameter int unsigned CLK_DIV = jtag_master_pkg::DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Expire is registered so it lines up with the cycle the count reads zero.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load_i) begin
      cnt_d = CNT_W'(CLK_DIV - 1);
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CNT_W'(1);
      expire_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG initiator: runs one TMS walk or TDI shift per command and returns captured TDO.
module jtag_shift_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned MAX_BITS = DEF_MAX_BITS,
  parameter int unsigned LEN_W    = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                rst_n,
  jtag_shift_master_if.slave  bus,
  output logic                jtag_tck_o,
  output logic                jtag_tms_o,
  output logic                jtag_tdi_o,
  input  logic                jtag_tdo_i
);

  localparam int unsigned      IDX_W   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                mode_q, mode_d;
  logic                exit_q, exit_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [MAX_BITS-1:0] tdo_q, tdo_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [1:0]          tdo_sync_q;

  logic                timer_load_c;
  logic                timer_expire;
  logic                enter_low_c;
  logic                last_bit_c;
  logic [LEN_W-1:0]    len_clamp_c;

  jtag_tck_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (timer_load_c),
    .expire_o (timer_expire)
  );

  // Next-state logic; TMS/TDI are only updated on entry to LOW so they settle a full half-period before TCK rises.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    mode_d       = mode_q;
    exit_d       = exit_q;
    data_d       = data_q;
    tdo_d        = tdo_q;
    tck_d        = tck_q;
    tms_d        = tms_q;
    tdi_d        = tdi_q;
    timer_load_c = 1'b0;
    enter_low_c  = 1'b0;
    len_clamp_c  = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
    last_bit_c   = (idx_q == IDX_W'(len_q - LEN_W'(1)));

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          mode_d = bus.cmd_tms_md;
          exit_d = bus.cmd_exit;
          len_d  = len_clamp_c;
          data_d = bus.cmd_data;
          idx_d  = '0;
          tdo_d  = '0;
          if (len_clamp_c == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_LOW;
            enter_low_c = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (timer_expire) begin
          state_d      = ST_HIGH;
          tck_d        = 1'b1;
          tdo_d[idx_q] = tdo_sync_q[1];
          timer_load_c = 1'b1;
        end
      end
      ST_HIGH: begin
        if (timer_expire) begin
          tck_d = 1'b0;
          if (last_bit_c) begin
            state_d = ST_DONE;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            state_d     = ST_LOW;
            enter_low_c = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_low_c) begin
      timer_load_c = 1'b1;
      tck_d        = 1'b0;
      if (mode_d) begin
        tms_d = data_d[idx_d];
        tdi_d = 1'b0;
      end else begin
        tms_d = exit_d && (idx_d == IDX_W'(len_d - LEN_W'(1)));
        tdi_d = data_d[idx_d];
      end
    end

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      exit_q      <= 1'b0;
      data_q      <= '0;
      tdo_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      tdo_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      exit_q      <= exit_d;
      data_q      <= data_d;
      tdo_q       <= tdo_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      tdo_sync_q  <= {tdo_sync_q[0], jtag_tdo_i};
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tdo   = tdo_q;
  assign jtag_tck_o    = tck_q;
  assign jtag_tms_o    = tms_q;
  assign jtag_tdi_o    = tdi_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: behavioural TAP holding IDCODE plus a cycle-level expectation model.
module tb_jtag_shift_master;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned MAX_BITS = 64;
  localparam int unsigned LEN_W    = 7;
  localparam logic [31:0] IDCODE   = 32'h1E20_0A6D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic jtag_tck, jtag_tms, jtag_tdi;
  logic jtag_tdo = 1'b0;

  jtag_shift_master_if #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) bus ();

  jtag_shift_master #(.CLK_DIV(CLK_DIV), .MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .jtag_tck_o (jtag_tck),
    .jtag_tms_o (jtag_tms),
    .jtag_tdi_o (jtag_tdi),
    .jtag_tdo_i (jtag_tdo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tck_rises = 0;
  logic [63:0] tms_hist = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge jtag_tck) begin
    tck_rises++;
    tms_hist = {tms_hist[62:0], jtag_tms};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural TAP (IEEE 1149.1 state graph, DR path holds IDCODE)
  localparam logic [3:0] T_TLR = 4'd0,  T_RTI = 4'd1,  T_SELDR = 4'd2,  T_CAPDR = 4'd3,
                         T_SHDR = 4'd4, T_EX1DR = 4'd5, T_PADR = 4'd6,  T_EX2DR = 4'd7,
                         T_UPDR = 4'd8, T_SELIR = 4'd9, T_CAPIR = 4'd10, T_SHIR = 4'd11,
                         T_EX1IR = 4'd12, T_PAIR = 4'd13, T_EX2IR = 4'd14, T_UPIR = 4'd15;

  logic [3:0]  tap_st = T_TLR;
  logic [31:0] tap_sr = '0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      T_TLR:   return tms ? T_TLR   : T_RTI;
      T_RTI:   return tms ? T_SELDR : T_RTI;
      T_SELDR: return tms ? T_SELIR : T_CAPDR;
      T_CAPDR: return tms ? T_EX1DR : T_SHDR;
      T_SHDR:  return tms ? T_EX1DR : T_SHDR;
      T_EX1DR: return tms ? T_UPDR  : T_PADR;
      T_PADR:  return tms ? T_EX2DR : T_PADR;
      T_EX2DR: return tms ? T_UPDR  : T_SHDR;
      T_UPDR:  return tms ? T_SELDR : T_RTI;
      T_SELIR: return tms ? T_TLR   : T_CAPIR;
      T_CAPIR: return tms ? T_EX1IR : T_SHIR;
      T_SHIR:  return tms ? T_EX1IR : T_SHIR;
      T_EX1IR: return tms ? T_UPIR  : T_PAIR;
      T_PAIR:  return tms ? T_EX2IR : T_PAIR;
      T_EX2IR: return tms ? T_UPIR  : T_SHIR;
      default: return tms ? T_SELDR : T_RTI;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    if (tap_st == T_CAPDR)     tap_sr <= IDCODE;
    else if (tap_st == T_SHDR) tap_sr <= {jtag_tdi, tap_sr[31:1]};
    tap_st <= tap_next(tap_st, jtag_tms);
  end

  always @(negedge jtag_tck) jtag_tdo = (tap_st == T_SHDR) ? tap_sr[0] : 1'b0;

  // ---------------- expectation model: phase + cycle offset since accept
  typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  bit          m_en = 1'b0;
  int          m_k = 0, m_n = 0;
  bit          m_mode = 1'b0, m_exit = 1'b0;
  logic [63:0] m_data = '0, m_exp = '0, m_rsp = '0, exp_rsp_next = '0;
  logic        m_tms = 1'b1, m_tdi = 1'b0;

  function automatic logic exp_tms_bit(input int b);
    return m_mode ? m_data[b] : (m_exit && (b == m_n - 1));
  endfunction

  function automatic logic exp_tdi_bit(input int b);
    return m_mode ? 1'b0 : m_data[b];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = M_IDLE; m_tms = 1'b1; m_tdi = 1'b0; m_rsp = '0; m_en = 1'b1;
    end else begin
      case (m_phase)
        M_IDLE: if (bus.cmd_valid) begin
          m_mode = bus.cmd_tms_md;
          m_exit = bus.cmd_exit;
          m_n    = (int'(bus.cmd_len) > int'(MAX_BITS)) ? int'(MAX_BITS) : int'(bus.cmd_len);
          m_data = bus.cmd_data;
          m_exp  = exp_rsp_next;
          m_rsp  = '0;
          m_k    = 1;
          if (m_n == 0) begin
            m_phase = M_DONE; m_rsp = m_exp;
          end else begin
            m_phase = M_BUSY;
          end
        end
        M_BUSY: if (m_k == 2 * m_n * int'(CLK_DIV)) begin
          m_phase = M_DONE;
          m_tms   = exp_tms_bit(m_n - 1);
          m_tdi   = exp_tdi_bit(m_n - 1);
          m_rsp   = m_exp;
        end else begin
          m_k++;
        end
        M_DONE: if (bus.rsp_ready) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      case (m_phase)
        M_BUSY: begin
          int j, b;
          j = m_k - 1;
          b = j / (2 * int'(CLK_DIV));
          chk("cyc.cmd_ready", 64'(bus.cmd_ready), 64'(0));
          chk("cyc.rsp_valid", 64'(bus.rsp_valid), 64'(0));
          chk("cyc.tck", 64'(jtag_tck), 64'((j / int'(CLK_DIV)) % 2));
          chk("cyc.tms", 64'(jtag_tms), 64'(exp_tms_bit(b)));
          chk("cyc.tdi", 64'(jtag_tdi), 64'(exp_tdi_bit(b)));
        end
        default: begin
          chk("cyc.cmd_ready", 64'(bus.cmd_ready), 64'(m_phase == M_IDLE));
          chk("cyc.rsp_valid", 64'(bus.rsp_valid), 64'(m_phase == M_DONE));
          chk("cyc.tck", 64'(jtag_tck), 64'(0));
          chk("cyc.tms", 64'(jtag_tms), 64'(m_tms));
          chk("cyc.tdi", 64'(jtag_tdi), 64'(m_tdi));
          chk("cyc.rsp_tdo", bus.rsp_tdo, m_rsp);
        end
      endcase
    end
  end

  // ---------------- directed command driver with hand-computed expectations
  task automatic run_cmd(input string name, input bit mode, input bit ext, input int len,
                         input logic [63:0] data, input logic [63:0] exp_rsp,
                         input int exp_lat, input int exp_pulses, input int bp);
    int t0, p0;
    bit got;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_tms_md = mode;
    bus.cmd_exit   = ext;
    bus.cmd_len    = LEN_W'(len);
    bus.cmd_data   = data;
    bus.rsp_ready  = 1'b0;
    exp_rsp_next   = exp_rsp;
    p0 = tck_rises;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    // keep offering a junk command while busy; it must be ignored
    bus.cmd_data = ~data;
    bus.cmd_len  = LEN_W'(1);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 3) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk({name, ".rsp_seen"}, 64'(got), 64'(1));
    if (!got) return;
    chk({name, ".latency"}, 64'(cyc - t0 + 1), 64'(exp_lat));
    chk({name, ".tck_pulses"}, 64'(tck_rises - p0), 64'(exp_pulses));
    chk({name, ".rsp_tdo"}, bus.rsp_tdo, exp_rsp);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({name, ".bp_valid"}, 64'(bus.rsp_valid), 64'(1));
      chk({name, ".bp_ready"}, 64'(bus.cmd_ready), 64'(0));
      chk({name, ".bp_tck"}, 64'(jtag_tck), 64'(0));
      chk({name, ".bp_rsp"}, bus.rsp_tdo, exp_rsp);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({name, ".idle_ready"}, 64'(bus.cmd_ready), 64'(1));
    chk({name, ".idle_valid"}, 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_tms_md = 1'b0;
    bus.cmd_exit   = 1'b0;
    bus.cmd_len    = '0;
    bus.cmd_data   = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.tck", 64'(jtag_tck), 64'(0));
    chk("reset.tms", 64'(jtag_tms), 64'(1));
    chk("reset.tdi", 64'(jtag_tdi), 64'(0));
    chk("reset.cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("reset.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset.rsp_tdo", bus.rsp_tdo, 64'(0));
    rst_n = 1'b1;

    run_cmd("reset_walk", 1'b1, 1'b0, 5, 64'h1F, 64'h0, 41, 5, 0);
    chk("reset_walk.tms_log", 64'(tms_hist[4:0]), 64'h1F);
    run_cmd("to_shift_dr", 1'b1, 1'b0, 4, 64'h2, 64'h0, 33, 4, 0);
    run_cmd("idcode", 1'b0, 1'b1, 32, 64'h0, 64'h1E20_0A6D, 257, 32, 0);
    chk("idcode.tms_log", 64'(tms_hist[31:0]), 64'h1);
    run_cmd("zero_len", 1'b0, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 0);
    run_cmd("backpressure", 1'b1, 1'b0, 2, 64'h1, 64'h0, 17, 2, 10);
    run_cmd("reenter_shift", 1'b1, 1'b0, 3, 64'h1, 64'h0, 25, 3, 0);
    run_cmd("shift_a5", 1'b0, 1'b0, 8, 64'hA5, 64'h6D, 65, 8, 0);
    run_cmd("shift_3c", 1'b0, 1'b0, 8, 64'h3C, 64'h0A, 65, 8, 0);
    run_cmd("shift_tdi_back", 1'b0, 1'b1, 32, 64'h0, 64'h3CA5_1E20, 257, 32, 0);

    // abort a 32-bit shift during the high half of bit 7
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_tms_md = 1'b0;
    bus.cmd_exit   = 1'b0;
    bus.cmd_len    = LEN_W'(32);
    bus.cmd_data   = 64'hDEAD_BEEF;
    exp_rsp_next   = 64'h0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (61) @(negedge clk);
    chk("midrst.in_high", 64'(jtag_tck), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.tck", 64'(jtag_tck), 64'(0));
    chk("midrst.tms", 64'(jtag_tms), 64'(1));
    chk("midrst.tdi", 64'(jtag_tdi), 64'(0));
    chk("midrst.cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("midrst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("midrst.rsp_tdo", bus.rsp_tdo, 64'(0));

    run_cmd("reset_walk2", 1'b1, 1'b0, 5, 64'h1F, 64'h0, 41, 5, 0);
    run_cmd("clamp", 1'b0, 1'b0, 100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 513, 64, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
